usb_tx_encoder: RTL and testbench
=================================

Name: usb_tx_encoder

Overview:
Downstream datapath of the USB transmit control unit. It consumes the load strobes (load_sync, load_data_pid, load_data_crc, load_ack, load_nack, load_stall, load_ena), start_read, clear and eop, and returns cnt_done.
It serialises each field LSB-first at the bit rate, performs bit stuffing and NRZI encoding, and generates EOP. Its outputs drive the full-speed D+/D- transceiver pins.

Parameters:
CLK_DIV, 4, system clocks per USB bit period (>=2)
DATA_PID, 8'hC3, byte sent on load_data_pid (DATA0)
MAX_BYTES, 64, maximum payload bytes; sets byte_count width

Ports:
clk  input  1  system clock
rst  input  1  reset
load_sync  input  1  load 8'h80 (SYNC)
load_data_pid  input  1  load DATA_PID
load_ack  input  1  load 8'hD2
load_nack  input  1  load 8'h5A
load_stall  input  1  load 8'h1E
load_data_crc  input  1  load crc_in, 16 bits
load_ena  input  1  start payload of byte_count bytes
clear  input  1  clear bit counter and cnt_done
start_read  input  1  shift enable
eop  input  1  start EOP sequence
tx_data  input  8  payload byte from TX FIFO
crc_in  input  16  final CRC16, LSB sent first
byte_count  input  $clog2(MAX_BYTES+1)  payload length, sampled on load_ena
cnt_done  output  1  one-cycle pulse: current field fully sent
fifo_rd  output  1  one-cycle pop of tx_data
d_plus  output  1  D+ line
d_minus  output  1  D- line
busy  output  1  field or EOP in progress

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - d_plus=1, d_minus=0 (J/idle).
  - cnt_done=0, fifo_rd=0, busy=0.
  - ones_cnt=0, bit_cnt=0.
  - State IDLE, divider 0.
  - Reset mid-packet returns the line to J at once and drops the packet.
- States: IDLE, SHIFT, STUFF, EOP_SE0, EOP_J.
- Load strobes, one cycle each:
  - Priority when several are high: sync > pid > ack > nack > stall > crc > ena.
  - Action: load the 16-bit shift register and set bits_left to 8, or 16 for CRC. Set busy=1 and state SHIFT.
  - load_sync also zeroes ones_cnt and restarts the divider.
  - ones_cnt is otherwise preserved across fields, because stuffing spans field boundaries.
  - A load during SHIFT/STUFF aborts the current field; the new load wins.
- load_ena:
  - Latch byte_count into bytes_left.
  - If byte_count is nonzero: load tx_data and pulse fifo_rd in the same cycle.
  - If byte_count is 0: pulse cnt_done the next cycle and return to IDLE.
- Bit strobe: fires when the divider reaches CLK_DIV-1. The divider is free-running while busy.
- SHIFT, at a strobe with start_read=1:
  - Send the LSB. A 0 toggles the line (J<->K); a 1 holds it.
  - Shift right and decrement bits_left.
  - ones_cnt increments on 1 and clears on 0.
  - If ones_cnt reaches 6, go to STUFF.
- At a strobe with start_read=0: no shift and the line holds.
- STUFF: at the next strobe, toggle the line (stuffed 0) without consuming data, clear ones_cnt and return to SHIFT. start_read is ignored here.
- Field end: reached when bits_left hits 0 and no stuff is pending. A stuff triggered by the final bit is emitted first.
  - Payload with bytes_left>1: decrement bytes_left, load tx_data, pulse fifo_rd, and continue with no gap in the bit stream.
  - Otherwise: pulse cnt_done for exactly 1 cycle, registered, and go to IDLE. busy stays 1 and the line holds.
- clear: zeroes bit_cnt and cnt_done only. It never touches the line or ones_cnt.
- eop:
  - Restart the divider.
  - EOP_SE0: d_plus=d_minus=0 for 2 bit periods.
  - EOP_J: J for 1 bit period.
  - Then IDLE with busy=0 and ones_cnt=0.
  - Load strobes during EOP are ignored.
- cnt_done is never asserted during EOP.

Test Plan:
- CLK_DIV=4, load_sync with start_read held -> line K,J,K,J,K,J,K,K, each held 4 clks; cnt_done pulses once after 32 clks.
- SYNC then load_ack -> line J,J,K,J,J,K,K,K; cnt_done after 8 strobes; no fifo_rd.
- SYNC then load_ena, byte_count=1, tx_data=8'hFF -> one fifo_rd; stuffed K/J toggle after the 5th data bit; cnt_done after 9 strobes.
- SYNC then load_ena, byte_count=3 -> fifo_rd pulses at load and at byte ends 1 and 2 with no idle strobe between bytes; a single cnt_done after 24 (+stuff) strobes.
- load_data_crc with crc_in=16'hA5F0, then eop -> 16 LSB-first bits; SE0 for 8 clks, J for 4 clks, busy falls, fifo_rd never asserted.
- rst asserted mid-payload -> d_plus=1/d_minus=0 and all outputs 0 immediately; a subsequent SYNC transmits normally.

Source files
------------

// File: rtl/usb_tx_encoder_if.sv
// usb_tx_encoder_if: control-unit <-> transmit encoder bus (load strobes, payload/CRC data, status, line pins)
//   master: transmit control unit (drives strobes and data, reads status and pins)
//   slave : usb_tx_encoder
interface usb_tx_encoder_if #(
  parameter int MAX_BYTES = 64
);
  localparam int BCW = $clog2(MAX_BYTES + 1);
  logic           load_sync;
  logic           load_data_pid;
  logic           load_ack;
  logic           load_nack;
  logic           load_stall;
  logic           load_data_crc;
  logic           load_ena;
  logic           clear;
  logic           start_read;
  logic           eop;
  logic [7:0]     tx_data;
  logic [15:0]    crc_in;
  logic [BCW-1:0] byte_count;
  logic           cnt_done;
  logic           fifo_rd;
  logic           d_plus;
  logic           d_minus;
  logic           busy;
  modport master (
    output load_sync, load_data_pid, load_ack, load_nack, load_stall, load_data_crc, load_ena,
    output clear, start_read, eop, tx_data, crc_in, byte_count,
    input  cnt_done, fifo_rd, d_plus, d_minus, busy
  );
  modport slave (
    input  load_sync, load_data_pid, load_ack, load_nack, load_stall, load_data_crc, load_ena,
    input  clear, start_read, eop, tx_data, crc_in, byte_count,
    output cnt_done, fifo_rd, d_plus, d_minus, busy
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: LSB-first serialiser with bit stuffing, NRZI and EOP for full-speed D+/D-
//   clk, rst : system clock, async active-high reset (line returns to J)
//   bus_if   : slave side of usb_tx_encoder_if (load strobes, tx_data/crc_in/byte_count in;
//              cnt_done, fifo_rd, d_plus, d_minus, busy out)
module usb_tx_encoder #(
  parameter int         CLK_DIV   = 4,
  parameter logic [7:0] DATA_PID  = 8'hC3,
  parameter int         MAX_BYTES = 64
) (
  input logic             clk,
  input logic             rst,
  usb_tx_encoder_if.slave bus_if
);
  localparam int BCW = $clog2(MAX_BYTES + 1);
  localparam int DW  = $clog2(CLK_DIV);
  typedef enum logic [2:0] {IDLE, SHIFT, STUFF, EOP_SE0, EOP_J} state_t;
  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [15:0]    sr_q, sr_d, ld_val;
  logic [4:0]     bl_q, bl_d;
  logic [2:0]     ones_q, ones_d, ones_inc;
  logic [BCW-1:0] bytes_q, bytes_d;
  logic           pay_q, pay_d, line_q, line_d, busy_q, busy_d, done_q, done_d;
  logic           strobe, in_eop, eop_go, hi, sel_crc, sel_ena, ld, fend, fifo_rd;
  assign strobe   = div_q == DW'(CLK_DIV - 1);
  assign in_eop   = state_q == EOP_SE0 || state_q == EOP_J;
  assign eop_go   = bus_if.eop && !in_eop;
  assign hi       = bus_if.load_sync | bus_if.load_data_pid | bus_if.load_ack | bus_if.load_nack | bus_if.load_stall;
  assign sel_crc  = bus_if.load_data_crc && !hi;
  assign sel_ena  = bus_if.load_ena && !hi && !bus_if.load_data_crc;
  assign ld       = !in_eop && (hi || bus_if.load_data_crc || bus_if.load_ena);
  assign ld_val   = bus_if.load_sync     ? 16'h0080 :
                    bus_if.load_data_pid ? {8'h00, DATA_PID} :
                    bus_if.load_ack      ? 16'h00D2 :
                    bus_if.load_nack     ? 16'h005A :
                    bus_if.load_stall    ? 16'h001E :
                    sel_crc              ? bus_if.crc_in : {8'h00, bus_if.tx_data};
  assign ones_inc = sr_q[0] ? ones_q + 3'd1 : 3'd0;
  always_comb begin
    state_d = state_q;
    div_d   = busy_q && !strobe ? div_q + DW'(1) : '0;
    sr_d    = sr_q;
    bl_d    = bus_if.clear && !in_eop ? 5'd0 : bl_q;
    ones_d  = ones_q;
    bytes_d = bytes_q;
    pay_d   = pay_q;
    line_d  = line_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fifo_rd = 1'b0;
    fend    = 1'b0;
    if (eop_go) begin
      state_d = EOP_SE0;
      div_d   = '0;
      bl_d    = 5'd1;
      line_d  = 1'b1;
      busy_d  = 1'b1;
    end else if (ld) begin
      state_d = SHIFT;
      busy_d  = 1'b1;
      sr_d    = ld_val;
      bl_d    = sel_crc ? 5'd16 : 5'd8;
      pay_d   = sel_ena;
      if (bus_if.load_sync) begin
        ones_d = '0;
        div_d  = '0;
      end
      if (sel_ena) begin
        bytes_d = bus_if.byte_count;
        fifo_rd = |bus_if.byte_count;
        // zero-length payload completes immediately without touching the line
        state_d = |bus_if.byte_count ? SHIFT : IDLE;
        done_d  = ~|bus_if.byte_count;
      end
    end else begin
      case (state_q)
        SHIFT: if (strobe && bus_if.start_read) begin
          line_d  = sr_q[0] ? line_q : ~line_q;
          sr_d    = sr_q >> 1;
          bl_d    = bl_q - 5'd1;
          ones_d  = ones_inc;
          state_d = ones_inc == 3'd6 ? STUFF : SHIFT;
          fend    = ones_inc != 3'd6 && bl_q == 5'd1;
        end
        STUFF: if (strobe) begin
          line_d  = ~line_q;
          ones_d  = '0;
          state_d = SHIFT;
          fend    = bl_q == 5'd0;
        end
        EOP_SE0: if (strobe) begin
          bl_d    = bl_q - 5'd1;
          state_d = bl_q == 5'd0 ? EOP_J : EOP_SE0;
        end
        EOP_J: if (strobe) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ones_d  = '0;
        end
        default: ;
      endcase
      // next payload byte is fetched on the same strobe so the bit stream has no gap
      if (fend) begin
        if (pay_q && bytes_q > BCW'(1)) begin
          bytes_d = bytes_q - BCW'(1);
          sr_d    = {8'h00, bus_if.tx_data};
          bl_d    = 5'd8;
          fifo_rd = 1'b1;
          state_d = SHIFT;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    end
    done_d = done_d && !bus_if.clear;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      sr_q    <= '0;
      bl_q    <= '0;
      ones_q  <= '0;
      bytes_q <= '0;
      pay_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sr_q    <= sr_d;
      bl_q    <= bl_d;
      ones_q  <= ones_d;
      bytes_q <= bytes_d;
      pay_q   <= pay_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus_if.d_plus   = line_q && state_q != EOP_SE0;
  assign bus_if.d_minus  = !line_q && state_q != EOP_SE0;
  assign bus_if.cnt_done = done_q;
  assign bus_if.fifo_rd  = fifo_rd;
  assign bus_if.busy     = busy_q;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: directed + randomized checks of the USB transmit encoder against a bit-level line model
module tb_usb_tx_encoder;
  localparam int CLK_DIV   = 4;
  localparam int MAX_BYTES = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  usb_tx_encoder_if #(.MAX_BYTES(MAX_BYTES)) bus();
  usb_tx_encoder #(.CLK_DIV(CLK_DIV), .DATA_PID(8'hC3), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst(rst), .bus_if(bus)
  );
  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, nrd = 0, ndone = 0, pidx = 0, m_ones = 0;
  logic m_lv = 1'b1, m_busy = 1'b0;
  logic [7:0] pay[$];
  logic bq[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic fr;
    fr = bus.fifo_rd;
    @(posedge clk);
    #1;
    cyc++;
    if (fr) begin
      nrd++;
      pidx++;
      bus.tx_data = pidx < pay.size() ? pay[pidx] : 8'h00;
    end
    if (bus.cnt_done) ndone++;
  endtask
  task automatic wait_strobe();
    do step(); while ((cyc - t0) % CLK_DIV != 0);
  endtask
  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) bq.push_back(v[i]);
  endtask
  // mask bits: 0 sync, 1 pid, 2 ack, 3 nack, 4 stall, 5 crc, 6 ena
  task automatic load(input logic [6:0] m);
    {bus.load_ena, bus.load_data_crc, bus.load_stall, bus.load_nack, bus.load_ack, bus.load_data_pid, bus.load_sync} = m;
    if (m[0] || !m_busy) t0 = cyc + 1;
    if (m[0]) m_ones = 0;
    m_busy = 1'b1;
    nrd = 0;
    ndone = 0;
    step();
    {bus.load_ena, bus.load_data_crc, bus.load_stall, bus.load_nack, bus.load_ack, bus.load_data_pid, bus.load_sync} = '0;
  endtask
  task automatic run_field(input int hold, input int exp_rd);
    logic lv[$];
    for (int h = 0; h < hold; h++) begin
      wait_strobe();
      chk("hold_line", 32'({bus.d_plus, bus.d_minus}), 32'({m_lv, ~m_lv}));
    end
    bus.start_read = 1'b1;
    foreach (bq[i]) begin
      if (!bq[i]) begin m_lv = ~m_lv; m_ones = 0; end
      else m_ones++;
      lv.push_back(m_lv);
      if (m_ones == 6) begin m_lv = ~m_lv; m_ones = 0; lv.push_back(m_lv); end
    end
    foreach (lv[i]) begin
      wait_strobe();
      chk("line", 32'({bus.d_plus, bus.d_minus}), 32'({lv[i], ~lv[i]}));
    end
    chk("done", 32'(bus.cnt_done), 32'd1);
    chk("done_count", 32'(ndone), 32'd1);
    chk("fifo_rd_count", 32'(nrd), 32'(exp_rd));
    step();
    chk("done_pulse", 32'(bus.cnt_done), 32'd0);
    bq.delete();
  endtask
  task automatic payload(input int n);
    logic [7:0] b;
    pay.delete();
    for (int i = 0; i < n; i++) begin
      b = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom);
      pay.push_back(b);
      push_bits({8'h00, b}, 8);
    end
    pidx = 0;
    bus.tx_data = pay[0];
    bus.byte_count = 7'(n);
    load(7'b1000000);
    run_field(0, n);
  endtask
  task automatic do_eop();
    bus.eop = 1'b1;
    step();
    bus.eop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("eop_line", 32'({bus.d_plus, bus.d_minus}), i < 8 ? 32'd0 : 32'd2);
      chk("eop_status", 32'({bus.busy, bus.cnt_done, bus.fifo_rd}), 32'd4);
      if (i == 3) bus.load_ack = 1'b1;
      step();
      bus.load_ack = 1'b0;
    end
    chk("eop_end", 32'({bus.d_plus, bus.d_minus, bus.busy}), 32'd4);
    m_lv = 1'b1;
    m_ones = 0;
    m_busy = 1'b0;
  endtask
  function automatic logic [7:0] pid_of(input int k);
    return k == 1 ? 8'hC3 : k == 2 ? 8'hD2 : k == 3 ? 8'h5A : 8'h1E;
  endfunction
  initial begin
    logic [15:0] v;
    int k;
    {bus.load_ena, bus.load_data_crc, bus.load_stall, bus.load_nack, bus.load_ack, bus.load_data_pid, bus.load_sync} = '0;
    bus.clear = 1'b0;
    bus.start_read = 1'b1;
    bus.eop = 1'b0;
    bus.tx_data = 8'h00;
    bus.crc_in = 16'h0000;
    bus.byte_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", 32'({bus.d_plus, bus.d_minus}), 32'd2);
    chk("rst_status", 32'({bus.cnt_done, bus.fifo_rd, bus.busy}), 32'd0);
    rst = 1'b0;
    step();
    // SYNC then ACK
    load(7'b0000001); push_bits(16'h0080, 8); run_field(0, 0);
    load(7'b0000100); push_bits(16'h00D2, 8); run_field(0, 0);
    do_eop();
    // SYNC then single 0xFF payload byte (stuff after 5th data bit)
    load(7'b0000001); push_bits(16'h0080, 8); run_field(0, 0);
    pay.delete(); pay.push_back(8'hFF); pidx = 0; bus.tx_data = 8'hFF; bus.byte_count = 7'd1;
    load(7'b1000000); push_bits(16'h00FF, 8); run_field(0, 1);
    do_eop();
    // SYNC then 3-byte payload
    load(7'b0000001); push_bits(16'h0080, 8); run_field(0, 0);
    payload(3);
    do_eop();
    // CRC from idle, then EOP
    bus.crc_in = 16'hA5F0;
    load(7'b0100000); push_bits(16'hA5F0, 16); run_field(0, 0);
    do_eop();
    // DATA PID, zero-length payload, clear, priority resolution, start_read hold
    load(7'b0000001); push_bits(16'h0080, 8); run_field(0, 0);
    load(7'b0000010); push_bits(16'h00C3, 8); run_field(0, 0);
    bus.byte_count = '0;
    load(7'b1000000);
    chk("len0_done", 32'(bus.cnt_done), 32'd1);
    chk("len0_rd", 32'(nrd), 32'd0);
    step();
    chk("len0_pulse", 32'(bus.cnt_done), 32'd0);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear_hold", 32'({bus.d_plus, bus.d_minus, bus.busy}), 32'({m_lv, ~m_lv, 1'b1}));
    load(7'b1111000); push_bits(16'h005A, 8); run_field(0, 0);
    bus.start_read = 1'b0;
    load(7'b0010000); push_bits(16'h001E, 8); run_field(2, 0);
    do_eop();
    // randomized packets
    for (int r = 0; r < 5; r++) begin
      load(7'b0000001); push_bits(16'h0080, 8); run_field(0, 0);
      k = $urandom_range(1, 4);
      load(7'(1 << k)); push_bits({8'h00, pid_of(k)}, 8); run_field(0, 0);
      payload($urandom_range(1, 4));
      v = 16'($urandom);
      bus.crc_in = v;
      load(7'b0100000); push_bits(v, 16); run_field(0, 0);
      do_eop();
    end
    // reset in the middle of a payload, then a clean SYNC
    load(7'b0000001); push_bits(16'h0080, 8); run_field(0, 0);
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(8'($urandom));
    pidx = 0; bus.tx_data = pay[0]; bus.byte_count = 7'd4;
    load(7'b1000000);
    repeat (20) step();
    rst = 1'b1;
    #1;
    chk("midrst_line", 32'({bus.d_plus, bus.d_minus}), 32'd2);
    chk("midrst_status", 32'({bus.cnt_done, bus.fifo_rd, bus.busy}), 32'd0);
    step();
    step();
    rst = 1'b0;
    m_lv = 1'b1; m_ones = 0; m_busy = 1'b0;
    step();
    load(7'b0000001); push_bits(16'h0080, 8); run_field(0, 0);
    do_eop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
